dvp_pix_capture: RTL and testbench
==================================

DVP_PIX_CAPTURE -- requirements
Module: dvp_pix_capture

Interface
REQ-001 Parameter IN_W, default 8: camera data bus width in bits.
REQ-002 Parameter BPP, default 2: bytes per pixel, legal 1..3; pixel width OUT_W = IN_W*BPP.
REQ-003 Parameter PIC_WAIT, default 10: vsync rising edges discarded after reset before capture may begin; legal 1..255.
REQ-004 Parameter H_PIX, default 640: expected pixels per line; legal 1..4095.
REQ-005 Parameter V_LINES, default 480: expected lines per frame; legal 1..4095.
REQ-006 Parameters CROP_X0/CROP_Y0/CROP_W/CROP_H, defaults 0/0/640/480: output window; CROP_X0+CROP_W ≤ H_PIX, CROP_Y0+CROP_H ≤ V_LINES.
REQ-007 cam_pclk  in  1  sole clock; all logic on its rising edge.
REQ-008 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-009 cam_href  in  1  line valid, high during active bytes.
REQ-010 cam_vsync  in  1  frame sync; its rising edge marks frame boundary.
REQ-011 cam_data  in  IN_W  camera byte, sampled when cam_href=1.
REQ-012 cap_en  in  1  capture enable, sampled only at vsync rising edges.
REQ-013 pix_valid  out  1  one-cycle strobe per output pixel.
REQ-014 pix_data  out  OUT_W  assembled pixel, first byte in MSBs.
REQ-015 pix_sof  out  1  high with the first in-window pixel of a frame.
REQ-016 pix_eol  out  1  high with the last in-window pixel of each line.
REQ-017 frame_done  out  1  one-cycle pulse when a captured frame ends.
REQ-018 frame_err  out  1  pulse coincident with frame_done when frame geometry was wrong.
REQ-019 frame_cnt  out  16  count of completed captured frames.

Function
REQ-020 vsync_d = cam_vsync registered; vs_rise = cam_vsync & ~vsync_d (single-cycle event per edge).
REQ-021 FSM states WAIT, IDLE, ACTIVE; reset state WAIT.
REQ-022 WAIT: skip_cnt increments on each vs_rise; on the PIC_WAIT-th vs_rise -> ACTIVE if cap_en=1, else IDLE.
REQ-023 IDLE: vs_rise with cap_en=1 -> ACTIVE; otherwise stay.
REQ-024 ACTIVE: on vs_rise, frame ends (REQ-031); next state ACTIVE if cap_en=1, else IDLE; cap_en drop mid-frame does not truncate the frame.
REQ-025 Byte assembly: byte_cnt 0..BPP-1 advances per cycle with cam_href=1; byte at byte_cnt==BPP-1 completes a pixel, byte_cnt -> 0; cam_href=0 forces byte_cnt=0.
REQ-026 x_cnt (12 bit): pixel index in line, +1 per completed pixel, cleared when cam_href=0; y_cnt (12 bit): +1 on cam_href falling edge, cleared on vs_rise.
REQ-027 pix_valid=1 one cycle after the completing byte's edge, only in ACTIVE and when CROP_X0 ≤ x_cnt < CROP_X0+CROP_W and CROP_Y0 ≤ y_cnt < CROP_Y0+CROP_H.
REQ-028 pix_sof = pix_valid & x==CROP_X0 & y==CROP_Y0; pix_eol = pix_valid & x==CROP_X0+CROP_W-1.
REQ-029 pix_data holds its last value while pix_valid=0.
REQ-030 Line error: cam_href falls with byte_cnt≠0 (partial pixel discarded, no pix_valid) or with pixel count ≠ H_PIX; latched in err_flag until frame end.
REQ-031 Frame end in ACTIVE (vs_rise): frame_done=1 next cycle; frame_err=1 same cycle if err_flag=1 or y_cnt≠V_LINES; frame_cnt+1, wraps 0xFFFF->0; err_flag cleared.
REQ-032 vs_rise in WAIT/IDLE: no frame_done, no frame_cnt change, err_flag cleared.
REQ-033 cam_href=1 concurrent with vs_rise: vs_rise processed first; the byte counts toward the new frame.
REQ-034 Pixel completed in the same cycle as an ACTIVE->IDLE transition belongs to the ended frame only if before vs_rise; bytes after vs_rise in IDLE never produce pix_valid.

Reset
REQ-035 sys_rst_n=0 at any edge: state WAIT, skip_cnt/byte_cnt/x_cnt/y_cnt/err_flag/vsync_d=0, all outputs 0 incl. pix_data and frame_cnt.
REQ-036 Reset mid-frame discards partial frame; after release PIC_WAIT vs_rise edges are skipped again.

Verification (bench params: IN_W=8, BPP=2, PIC_WAIT=2, H_PIX=4, V_LINES=2, crop 0/0/4/2 unless noted)
REQ-037 Two vsync pulses then frame of 2 lines x 8 bytes 0x01..0x10, cap_en=1 -> no output during first 2 frames; pixels 0x0102,0x0304,...,0x0F10, pix_sof on 0x0102, pix_eol on 0x0708 and 0x0F10, frame_done, frame_err=0, frame_cnt=1.
REQ-038 Line with 7 bytes -> 3 pixels only, last byte discarded, frame_err=1 at frame_done.
REQ-039 Crop 1/1/2/1 -> exactly 2 pixels per frame (line 1, x=1,2), pix_sof and pix_eol on the pair's first/last respectively.
REQ-040 cap_en dropped mid-frame -> frame completes with frame_done; next frame produces no pix_valid; cap_en reasserted -> capture resumes following frame.
REQ-041 sys_rst_n pulsed low mid-line -> all outputs 0 next cycle; capture resumes only after 2 further vs_rise edges.
REQ-042 Force frame_cnt to 0xFFFF (65535 frames or preload) -> next frame_done wraps it to 0x0000.

Source files
------------

// File: rtl/dvp_pix_capture.sv
// DVP camera pixel capture: packs bytes into pixels, crops to a window,
// and reports per-frame completion, geometry errors and a frame count.
// Ports: cam_pclk/sys_rst_n (sync, active-low), cam_href/cam_vsync/cam_data,
//   cap_en -> pix_valid/pix_data/pix_sof/pix_eol, frame_done/frame_err/frame_cnt.
module dvp_pix_capture #(
   parameter int IN_W     = 8,
   parameter int BPP      = 2,
   parameter int PIC_WAIT = 10,
   parameter int H_PIX    = 640,
   parameter int V_LINES  = 480,
   parameter int CROP_X0  = 0,
   parameter int CROP_Y0  = 0,
   parameter int CROP_W   = 640,
   parameter int CROP_H   = 480
) (
   input  logic                cam_pclk,
   input  logic                sys_rst_n,
   input  logic                cam_href,
   input  logic                cam_vsync,
   input  logic [IN_W-1:0]     cam_data,
   input  logic                cap_en,
   output logic                pix_valid,
   output logic [IN_W*BPP-1:0] pix_data,
   output logic                pix_sof,
   output logic                pix_eol,
   output logic                frame_done,
   output logic                frame_err,
   output logic [15:0]         frame_cnt
);

   localparam int OUT_W = IN_W * BPP;

   localparam logic [12:0] X_LO   = 13'(CROP_X0);
   localparam logic [12:0] X_WID  = 13'(CROP_W);
   localparam logic [12:0] X_LAST = 13'(CROP_X0 + CROP_W - 1);
   localparam logic [12:0] Y_LO   = 13'(CROP_Y0);
   localparam logic [12:0] Y_WID  = 13'(CROP_H);
   localparam logic [11:0] H_EXP  = 12'(H_PIX);
   localparam logic [11:0] V_EXP  = 12'(V_LINES);
   localparam logic [1:0]  B_LAST = 2'(BPP - 1);
   localparam logic [7:0]  SK_END = 8'(PIC_WAIT - 1);

   typedef enum logic [1:0] {
      S_WAIT,
      S_IDLE,
      S_ACTIVE
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       skip_q, skip_d;
   logic [1:0]       byte_q, byte_d;
   logic [11:0]      x_q, x_d;
   logic [11:0]      y_q, y_d;
   logic             err_q, err_d;
   logic             vsync_q, vsync_d;
   logic             href_q, href_d;
   logic [OUT_W-1:0] sh_q, sh_d;
   logic             pv_q, pv_d;
   logic [OUT_W-1:0] pd_q, pd_d;
   logic             sof_q, sof_d;
   logic             eol_q, eol_d;
   logic             done_q, done_d;
   logic             ferr_q, ferr_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;

   logic             vs_rise, href_fall, pix_done, line_err, in_win;
   logic [OUT_W-1:0] sh_nxt;
   logic [11:0]      y_end, y_pix;
   logic [12:0]      x_off, y_off;

   always_comb begin
      vs_rise   = cam_vsync & ~vsync_q;
      href_fall = href_q & ~cam_href;
      pix_done  = cam_href & (byte_q == B_LAST);
      sh_nxt    = (sh_q << IN_W) | OUT_W'(cam_data);
      line_err  = href_fall & ((byte_q != 2'd0) | (x_q != H_EXP));
      // A line ending on the frame edge still counts toward that frame.
      y_end     = href_fall ? y_q + 12'd1 : y_q;
      // A byte arriving with the vsync edge belongs to the new frame.
      y_pix     = vs_rise ? 12'd0 : y_q;

      state_d     = state_q;
      skip_d      = skip_q;
      done_d      = 1'b0;
      ferr_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;

      unique case (state_q)
         S_WAIT: begin
            if (vs_rise) begin
               skip_d = skip_q + 8'd1;
               if (skip_q == SK_END)
                  state_d = cap_en ? S_ACTIVE : S_IDLE;
            end
         end
         S_IDLE: begin
            if (vs_rise && cap_en)
               state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (vs_rise) begin
               done_d      = 1'b1;
               ferr_d      = err_q | line_err | (y_end != V_EXP);
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = cap_en ? S_ACTIVE : S_IDLE;
            end
         end
         default: state_d = S_WAIT;
      endcase

      vsync_d = cam_vsync;
      href_d  = cam_href;
      err_d   = vs_rise ? 1'b0 : (err_q | line_err);
      sh_d    = cam_href ? sh_nxt : sh_q;

      if (!cam_href) begin
         byte_d = 2'd0;
         x_d    = 12'd0;
      end else if (pix_done) begin
         byte_d = 2'd0;
         x_d    = x_q + 12'd1;
      end else begin
         byte_d = byte_q + 2'd1;
         x_d    = x_q;
      end

      if (vs_rise)
         y_d = 12'd0;
      else if (href_fall)
         y_d = y_q + 12'd1;
      else
         y_d = y_q;

      // Offset compares wrap below the window origin, so one test covers both bounds.
      x_off  = {1'b0, x_q} - X_LO;
      y_off  = {1'b0, y_pix} - Y_LO;
      in_win = (x_off < X_WID) & (y_off < Y_WID);

      pv_d  = pix_done & in_win & (state_d == S_ACTIVE);
      pd_d  = pv_d ? sh_nxt : pd_q;
      sof_d = pv_d & ({1'b0, x_q} == X_LO) & ({1'b0, y_pix} == Y_LO);
      eol_d = pv_d & ({1'b0, x_q} == X_LAST);
   end

   always_ff @(posedge cam_pclk) begin
      if (!sys_rst_n) begin
         state_q     <= S_WAIT;
         skip_q      <= '0;
         byte_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         err_q       <= 1'b0;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         sh_q        <= '0;
         pv_q        <= 1'b0;
         pd_q        <= '0;
         sof_q       <= 1'b0;
         eol_q       <= 1'b0;
         done_q      <= 1'b0;
         ferr_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         skip_q      <= skip_d;
         byte_q      <= byte_d;
         x_q         <= x_d;
         y_q         <= y_d;
         err_q       <= err_d;
         vsync_q     <= vsync_d;
         href_q      <= href_d;
         sh_q        <= sh_d;
         pv_q        <= pv_d;
         pd_q        <= pd_d;
         sof_q       <= sof_d;
         eol_q       <= eol_d;
         done_q      <= done_d;
         ferr_q      <= ferr_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pix_valid  = pv_q;
   assign pix_data   = pd_q;
   assign pix_sof    = sof_q;
   assign pix_eol    = eol_q;
   assign frame_done = done_q;
   assign frame_err  = ferr_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dvp_pix_capture.sv
// Bench for dvp_pix_capture: full-window and cropped instances share stimulus
// and are compared against a frame/line level model of the capture rules.
module tb_dvp_pix_capture;

   localparam int PIC_WAIT = 2;
   localparam int H_PIX    = 4;
   localparam int V_LINES  = 2;
   localparam int B_X0 = 1, B_Y0 = 1, B_W = 2, B_H = 1;

   logic        cam_pclk = 1'b0;
   logic        sys_rst_n, cam_href, cam_vsync, cap_en;
   logic [7:0]  cam_data;
   logic        pv_a, sof_a, eol_a, dn_a, fe_a;
   logic [15:0] pd_a, fc_a;
   logic        pv_b, sof_b, eol_b, dn_b, fe_b;
   logic [15:0] pd_b, fc_b;

   always #5 cam_pclk = ~cam_pclk;

   dvp_pix_capture #(
      .IN_W(8), .BPP(2), .PIC_WAIT(PIC_WAIT), .H_PIX(H_PIX), .V_LINES(V_LINES),
      .CROP_X0(0), .CROP_Y0(0), .CROP_W(4), .CROP_H(2)
   ) dut_a (
      .cam_pclk(cam_pclk), .sys_rst_n(sys_rst_n), .cam_href(cam_href),
      .cam_vsync(cam_vsync), .cam_data(cam_data), .cap_en(cap_en),
      .pix_valid(pv_a), .pix_data(pd_a), .pix_sof(sof_a), .pix_eol(eol_a),
      .frame_done(dn_a), .frame_err(fe_a), .frame_cnt(fc_a)
   );

   dvp_pix_capture #(
      .IN_W(8), .BPP(2), .PIC_WAIT(PIC_WAIT), .H_PIX(H_PIX), .V_LINES(V_LINES),
      .CROP_X0(B_X0), .CROP_Y0(B_Y0), .CROP_W(B_W), .CROP_H(B_H)
   ) dut_b (
      .cam_pclk(cam_pclk), .sys_rst_n(sys_rst_n), .cam_href(cam_href),
      .cam_vsync(cam_vsync), .cam_data(cam_data), .cap_en(cap_en),
      .pix_valid(pv_b), .pix_data(pd_b), .pix_sof(sof_b), .pix_eol(eol_b),
      .frame_done(dn_b), .frame_err(fe_b), .frame_cnt(fc_b)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        sof;
      logic        eol;
   } px_t;

   typedef struct packed {
      logic        err;
      logic [15:0] cnt;
   } fr_t;

   px_t qa[$], qb[$];
   fr_t fa[$], fb[$];
   px_t la[2048], lb[2048];
   fr_t lf[512];
   int  la_n = 0, lb_n = 0, lf_n = 0;
   logic [15:0] last_a = 0, last_b = 0;

   int n_chk = 0, n_pass = 0;

   bit          m_wait, m_act, m_err;
   int          m_skip, m_lines;
   logic [15:0] m_cnt;

   task automatic check(input string nm, input bit ok,
                        input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic chk_side(input bit b, input logic pv, input logic [15:0] d,
                           input logic s, input logic e, input logic dn,
                           input logic fe, input logic [15:0] fc);
      px_t ex;
      fr_t fx;
      int  n;
      if (pv) begin
         n = b ? qb.size() : qa.size();
         if (n == 0) begin
            check(b ? "b_extra_pix" : "a_extra_pix", 1'b0, 64'({d, s, e}), 0);
         end else begin
            ex = b ? qb.pop_front() : qa.pop_front();
            check(b ? "b_pix" : "a_pix", {d, s, e} == ex,
                  64'({d, s, e}), 64'(ex));
         end
         if (b) begin
            last_b = d;
            if (lb_n < 2048) lb[lb_n] = {d, s, e};
            lb_n++;
         end else begin
            last_a = d;
            if (la_n < 2048) la[la_n] = {d, s, e};
            la_n++;
         end
      end else begin
         check(b ? "b_hold" : "a_hold", {d, s, e} == {(b ? last_b : last_a), 2'b00},
               64'({d, s, e}), 64'({(b ? last_b : last_a), 2'b00}));
      end
      if (dn) begin
         n = b ? fb.size() : fa.size();
         if (n == 0) begin
            check(b ? "b_extra_done" : "a_extra_done", 1'b0, 64'({fe, fc}), 0);
         end else begin
            fx = b ? fb.pop_front() : fa.pop_front();
            check(b ? "b_frame" : "a_frame", {fe, fc} == fx,
                  64'({fe, fc}), 64'(fx));
         end
         if (!b) begin
            if (lf_n < 512) lf[lf_n] = {fe, fc};
            lf_n++;
         end
      end else begin
         check(b ? "b_err_no_done" : "a_err_no_done", fe == 1'b0, 64'(fe), 0);
      end
   endtask

   initial forever begin
      @(posedge cam_pclk);
      #1;
      if (!sys_rst_n) begin
         check("reset_out_a", {pv_a, pd_a, sof_a, eol_a, dn_a, fe_a, fc_a} == 0,
               64'({pv_a, pd_a, sof_a, eol_a, dn_a, fe_a, fc_a}), 0);
         check("reset_out_b", {pv_b, pd_b, sof_b, eol_b, dn_b, fe_b, fc_b} == 0,
               64'({pv_b, pd_b, sof_b, eol_b, dn_b, fe_b, fc_b}), 0);
         last_a = 0;
         last_b = 0;
      end else begin
         chk_side(1'b0, pv_a, pd_a, sof_a, eol_a, dn_a, fe_a, fc_a);
         chk_side(1'b1, pv_b, pd_b, sof_b, eol_b, dn_b, fe_b, fc_b);
      end
   end

   task automatic tick();
      @(negedge cam_pclk);
   endtask

   task automatic model_reset();
      m_wait  = 1;
      m_skip  = 0;
      m_act   = 0;
      m_lines = 0;
      m_err   = 0;
      m_cnt   = 0;
   endtask

   task automatic model_vs();
      fr_t f;
      if (m_wait) begin
         m_skip++;
         if (m_skip == PIC_WAIT) begin
            m_wait = 0;
            m_act  = cap_en;
         end
      end else begin
         if (m_act) begin
            m_cnt++;
            f.err = m_err || (m_lines != V_LINES);
            f.cnt = m_cnt;
            fa.push_back(f);
            fb.push_back(f);
         end
         m_act = cap_en;
      end
      m_lines = 0;
      m_err   = 0;
   endtask

   task automatic push_px(input int x, input int y, input logic [15:0] d);
      if (m_act) begin
         if (x < 4 && y < 2)
            qa.push_back({d, (x == 0 && y == 0), (x == 3)});
         if (x >= B_X0 && x < B_X0 + B_W && y >= B_Y0 && y < B_Y0 + B_H)
            qb.push_back({d, (x == B_X0 && y == B_Y0), (x == B_X0 + B_W - 1)});
      end
   endtask

   task automatic vs_pulse();
      tick();
      cam_href  = 0;
      cam_vsync = 1;
      model_vs();
      tick();
      tick();
      cam_vsync = 0;
      tick();
      tick();
   endtask

   task automatic drive_bytes(input int nb, input bit rnd, input int base, input bit vsf);
      logic [15:0] acc;
      logic [7:0]  b;
      acc = 0;
      for (int i = 0; i < nb; i++) begin
         tick();
         if (vsf && i == 0) begin
            cam_vsync = 1;
            model_vs();
         end
         if (i == 2) cam_vsync = 0;
         b        = rnd ? 8'($urandom) : 8'(base + i);
         cam_href = 1;
         cam_data = b;
         acc      = {acc[7:0], b};
         if (i % 2 == 1) push_px(i / 2, m_lines, acc);
      end
   endtask

   task automatic send_line(input int nb, input bit rnd, input int base, input bit vsf);
      drive_bytes(nb, rnd, base, vsf);
      tick();
      cam_href  = 0;
      cam_vsync = 0;
      if ((nb % 2 != 0) || (nb / 2 != H_PIX)) m_err = 1;
      m_lines++;
      tick();
      tick();
   endtask

   task automatic reset_mid(input int nb);
      drive_bytes(nb, 1'b1, 0, 1'b0);
      tick();
      sys_rst_n = 0;
      cam_href  = 0;
      cam_vsync = 0;
      model_reset();
      tick();
      sys_rst_n = 1;
      tick();
      check("rst_queues_empty", qa.size() + qb.size() + fa.size() + fb.size() == 0,
            64'(qa.size() + qb.size() + fa.size() + fb.size()), 0);
   endtask

   int  s, sb, sf;
   bit  pend_vs;
   int  nl, nb, r;

   initial begin
      sys_rst_n = 0;
      cam_href  = 0;
      cam_vsync = 0;
      cam_data  = 0;
      cap_en    = 0;
      model_reset();
      tick();
      tick();
      tick();
      sys_rst_n = 1;

      cap_en = 1;
      send_line(8, 1'b1, 0, 1'b0);
      vs_pulse();
      send_line(8, 1'b1, 0, 1'b0);
      vs_pulse();
      check("d37_quiet_wait", la_n == 0 && lf_n == 0, 64'(la_n + lf_n), 0);
      s = la_n; sb = lb_n; sf = lf_n;
      send_line(8, 1'b0, 1, 1'b0);
      send_line(8, 1'b0, 9, 1'b0);
      vs_pulse();
      check("d37_npix", la_n - s == 8, 64'(la_n - s), 8);
      check("d37_p0", la[s] == {16'h0102, 2'b10}, 64'(la[s]), 64'({16'h0102, 2'b10}));
      check("d37_p1", la[s+1] == {16'h0304, 2'b00}, 64'(la[s+1]), 64'({16'h0304, 2'b00}));
      check("d37_p3", la[s+3] == {16'h0708, 2'b01}, 64'(la[s+3]), 64'({16'h0708, 2'b01}));
      check("d37_p7", la[s+7] == {16'h0F10, 2'b01}, 64'(la[s+7]), 64'({16'h0F10, 2'b01}));
      check("d37_frame", lf_n == sf + 1 && lf[sf] == {1'b0, 16'd1},
            64'(lf[sf]), 64'({1'b0, 16'd1}));
      check("d39_npix", lb_n - sb == 2, 64'(lb_n - sb), 2);
      check("d39_p0", lb[sb] == {16'h0B0C, 2'b10}, 64'(lb[sb]), 64'({16'h0B0C, 2'b10}));
      check("d39_p1", lb[sb+1] == {16'h0D0E, 2'b01}, 64'(lb[sb+1]), 64'({16'h0D0E, 2'b01}));

      s = la_n; sf = lf_n;
      send_line(7, 1'b0, 1, 1'b0);
      send_line(8, 1'b0, 1, 1'b0);
      vs_pulse();
      check("d38_npix", la_n - s == 7, 64'(la_n - s), 7);
      check("d38_p2", la[s+2] == {16'h0506, 2'b00}, 64'(la[s+2]), 64'({16'h0506, 2'b00}));
      check("d38_frame", lf[sf] == {1'b1, 16'd2}, 64'(lf[sf]), 64'({1'b1, 16'd2}));

      s = la_n; sf = lf_n;
      send_line(8, 1'b1, 0, 1'b0);
      cap_en = 0;
      send_line(8, 1'b1, 0, 1'b0);
      vs_pulse();
      check("d40_npix_full", la_n - s == 8, 64'(la_n - s), 8);
      check("d40_frame", lf_n == sf + 1 && lf[sf] == {1'b0, 16'd3},
            64'(lf[sf]), 64'({1'b0, 16'd3}));
      s = la_n;
      send_line(8, 1'b1, 0, 1'b0);
      send_line(8, 1'b1, 0, 1'b0);
      check("d40_idle_quiet", la_n == s, 64'(la_n - s), 0);
      cap_en = 1;
      vs_pulse();
      check("d40_no_done_idle", lf_n == sf + 1, 64'(lf_n - sf), 1);
      send_line(8, 1'b1, 0, 1'b0);
      send_line(8, 1'b1, 0, 1'b0);
      vs_pulse();
      check("d40_resume", la_n - s == 8 && lf[sf+1] == {1'b0, 16'd4},
            64'(la_n - s), 8);

      reset_mid(5);
      s = la_n; sf = lf_n;
      send_line(8, 1'b1, 0, 1'b0);
      vs_pulse();
      send_line(8, 1'b1, 0, 1'b0);
      check("d41_quiet", la_n == s && lf_n == sf, 64'(la_n - s), 0);
      vs_pulse();
      send_line(8, 1'b1, 0, 1'b0);
      send_line(8, 1'b1, 0, 1'b0);
      vs_pulse();
      check("d41_resume", la_n - s == 8 && lf[sf] == {1'b0, 16'd1},
            64'(lf[sf]), 64'({1'b0, 16'd1}));

      pend_vs = 0;
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 19) == 0) begin
            reset_mid($urandom_range(1, 7));
            pend_vs = 0;
         end
         nl = $urandom_range(1, 3);
         for (int l = 0; l < nl; l++) begin
            r  = $urandom_range(0, 9);
            nb = (r < 6) ? 8 : (r == 6) ? 7 : (r == 7) ? 6 : (r == 8) ? 9 : 10;
            if ($urandom_range(0, 7) == 0) cap_en = ~cap_en;
            send_line(nb, 1'b1, 0, pend_vs && l == 0);
         end
         cap_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) pend_vs = 1;
         else begin
            pend_vs = 0;
            vs_pulse();
         end
      end
      if (pend_vs) vs_pulse();

      cap_en = 1;
      vs_pulse();
      vs_pulse();
      tick();
      force dut_a.frame_cnt_q = 16'hFFFF;
      force dut_b.frame_cnt_q = 16'hFFFF;
      tick();
      release dut_a.frame_cnt_q;
      release dut_b.frame_cnt_q;
      m_cnt = 16'hFFFF;
      sf = lf_n;
      send_line(8, 1'b1, 0, 1'b0);
      send_line(8, 1'b1, 0, 1'b0);
      vs_pulse();
      check("d42_wrap", lf_n == sf + 1 && lf[sf] == {1'b0, 16'h0000},
            64'(lf[sf]), 64'({1'b0, 16'h0000}));
      check("d42_cnt_out", fc_a == 16'h0000 && fc_b == 16'h0000,
            64'({fc_a, fc_b}), 0);

      tick();
      tick();
      check("end_queues_empty", qa.size() + qb.size() + fa.size() + fb.size() == 0,
            64'(qa.size() + qb.size() + fa.size() + fb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
